// File: rtl/up_down_counter.sv
// Structural up/down counter: one T flip-flop per bit, toggled by a ripple
// carry (up) or borrow (down) chain. Wraps silently in both directions.

module udc_t_ff (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

module up_down_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] up_chain;
  logic [WIDTH-1:0] dn_chain;
  logic [WIDTH-1:0] toggle;

  // Chain bit i is true when every lower bit is 1 (up) or 0 (down), so
  // bit i flips exactly when the lower bits are about to carry or borrow.
  assign up_chain[0] = 1'b1;
  assign dn_chain[0] = 1'b1;

  genvar i;
  generate
    for (i = 1; i < WIDTH; i++) begin : g_chain
      assign up_chain[i] = up_chain[i-1] &  q[i-1];
      assign dn_chain[i] = dn_chain[i-1] & ~q[i-1];
    end

    for (i = 0; i < WIDTH; i++) begin : g_bit
      assign toggle[i] = mode ? up_chain[i] : dn_chain[i];

      udc_t_ff u_tff (
        .clk (clk),
        .rst (rst),
        .t   (toggle[i]),
        .q   (q[i])
      );
    end
  endgenerate

  assign count = q;

endmodule

// File: tb/tb_up_down_counter.sv
// Self-checking bench for up_down_counter: vector table, directed corner
// sequences and a randomized soak against an arithmetic reference model.

module tb_up_down_counter;

  localparam int W   = 3;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         rst;
  logic         mode;
  logic [W-1:0] count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic         rst;
    logic         mode;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  vec_t vecs[$];

  up_down_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .mode  (mode),
    .count (count)
  );

  // clock: posedges at 5,15,25,...; negedges at 10,20,...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: count=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic int next_val(input int cur, input logic up);
    return up ? (cur + 1) % MOD : (cur + MOD - 1) % MOD;
  endfunction

  // All tasks below start and end just after a negedge of clk.
  task automatic do_reset();
    rst = 1'b0;
    #1 check("reset_clear", count, '0);
    @(negedge clk);
    check("reset_hold", count, '0);
    rst = 1'b1;
  endtask

  task automatic step(input logic m, input int exp, input string name);
    mode = m;
    @(negedge clk);
    check(name, count, exp[W-1:0]);
  endtask

  task automatic add_vec(input logic r, input logic m, input int e, input string n);
    vec_t v;
    v.rst  = r;
    v.mode = m;
    v.exp  = e[W-1:0];
    v.name = n;
    vecs.push_back(v);
  endtask

  initial begin
    int m_cnt;
    int rst_timer;
    int mode_timer;
    int up_seq[10];
    int dn_seq[9];

    up_seq = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    dn_seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

    add_vec(1'b0, 1'b1, 0, "tbl_reset");
    add_vec(1'b0, 1'b1, 0, "tbl_reset");
    foreach (up_seq[k]) add_vec(1'b1, 1'b1, up_seq[k], "tbl_up");
    add_vec(1'b0, 1'b0, 0, "tbl_reset");
    foreach (dn_seq[k]) add_vec(1'b1, 1'b0, dn_seq[k], "tbl_down");

    rst  = 1'b1;
    mode = 1'b1;
    #2 rst = 1'b0;
    #1 check("power_on_reset", count, '0);
    @(negedge clk);
    check("power_on_hold", count, '0);

    // vector table: inputs applied at a negedge, result checked one edge later
    foreach (vecs[k]) begin
      rst  = vecs[k].rst;
      mode = vecs[k].mode;
      @(negedge clk);
      check(vecs[k].name, count, vecs[k].exp);
    end

    // async reset between edges while count=5, held across 3 edges
    do_reset();
    for (int k = 1; k <= 5; k++) step(1'b1, k, "async_pre");
    #2 rst = 1'b0;
    #1 check("async_clear_midcycle", count, '0);
    repeat (3) begin
      @(posedge clk);
      #1 check("async_hold", count, '0);
    end
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1, "async_release");

    // direction change: up to 4, down to 1, up again
    @(negedge clk);
    do_reset();
    for (int k = 1; k <= 4; k++) step(1'b1, k, "dir_up");
    step(1'b0, 3, "dir_down");
    step(1'b0, 2, "dir_down");
    step(1'b0, 1, "dir_down");
    step(1'b1, 2, "dir_up_again");
    step(1'b1, 3, "dir_up_again");

    // short reset pulse mid-operation at count=6
    do_reset();
    for (int k = 1; k <= 6; k++) step(1'b1, k, "pulse_pre");
    #1 rst = 1'b0;
    #1 check("pulse_clear", count, '0);
    #1 rst = 1'b1;
    @(negedge clk);
    check("pulse_resume", count, 1);
    step(1'b1, 2, "pulse_resume");

    // random soak: rst toggles every 100-200 units, mode every 50-100 units
    do_reset();
    m_cnt      = 0;
    rst_timer  = $urandom_range(20, 10);
    mode_timer = $urandom_range(10, 5);
    mode       = 1'($urandom_range(1, 0));
    for (int cyc = 0; cyc < 90; cyc++) begin
      rst_timer--;
      mode_timer--;
      if (mode_timer <= 0) begin
        mode       = ~mode;
        mode_timer = $urandom_range(10, 5);
      end
      if (rst_timer <= 0) begin
        rst       = ~rst;
        rst_timer = $urandom_range(20, 10);
        if (!rst) begin
          m_cnt = 0;
          #1 check("soak_async_clear", count, '0);
        end
      end
      @(posedge clk);
      m_cnt = rst ? next_val(m_cnt, mode) : 0;
      @(negedge clk);
      check("soak", count, m_cnt[W-1:0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
